// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//
// Fetches one 32-bit instruction word at a time from program memory and
// presents its decoded fields to the downstream ALU/writeback stage.
// The control path is a three-state FSM:
//   FETCH : request the word at pc and wait for prog_ack
//   ISSUE : hold the decoded instruction until the consumer takes it
//   HALT  : terminal state; only rst_n leaves it
//
// Instruction word layout:
//   [31:24] op  [23:22] src1  [21:20] src2  [19:16] rf_addr
//   [15:8]  mem_addr          [7:0]   imm
//
// Optional build macro:
//   DECODE_ILLEGAL_TRAP_EN - opcodes outside 0x00-0x11, 0x1B-0x20 and 0xFF
//                            are trapped (illegal_op=1, halt=1) instead of
//                            being issued. The illegal_op port exists only
//                            in this build.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   prog_req/addr     program-memory read request and address (= pc)
//   prog_ack/data     program-memory data valid and instruction word
//   stall             consumer not ready; holds the issued instruction
//   jump_en/target    redirect; loads pc and restarts fetching
//   op_code .. imm    decoded fields of the held instruction
//   instr_valid       decoded fields valid
//   pc                address of the held (or being fetched) instruction
//   halt              core halted
//   illegal_op        illegal-opcode trap (DECODE_ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                prog_req,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic                prog_ack,
  input  logic [31:0]         prog_data,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [IWIDTH-1:0]   op_code,
  output logic [1:0]          source1_choice,
  output logic [1:0]          source2_choice,
  output logic [3:0]          rf_addr,
  output logic [7:0]          mem_addr,
  output logic [WIDTH-1:0]    imm,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halt
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  prog_req_reg, prog_req_next;
  logic [PC_WIDTH-1:0]   pc_reg, pc_next;
  logic                  valid_reg, valid_next;
  logic                  halt_reg, halt_next;
  logic [IWIDTH-1:0]     op_code_reg, op_code_next;
  logic [1:0]            src1_reg, src1_next;
  logic [1:0]            src2_reg, src2_next;
  logic [3:0]            rf_addr_reg, rf_addr_next;
  logic [7:0]            mem_addr_reg, mem_addr_next;
  logic [WIDTH-1:0]      imm_reg, imm_next;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  illegal_reg, illegal_next;
  logic                  is_legal;
`endif

  logic [7:0]            op_byte;
  logic [IWIDTH-1:0]     op_ext;
  logic [WIDTH-1:0]      imm_ext;
  logic                  ack_take;
  logic                  is_halt_op;

  assign op_byte    = prog_data[31:24];
  assign is_halt_op = (op_byte == 8'hFF);

  // An ack only counts while our request is actually out; this drops any
  // ack left over from a request abandoned by reset.
  assign ack_take = (state_reg == FETCH) && prog_req_reg && prog_ack;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign is_legal = (op_byte <= 8'h11) ||
                    ((op_byte >= 8'h1B) && (op_byte <= 8'h20)) ||
                    is_halt_op;
`endif

  // Zero-extend or truncate the 8-bit opcode and immediate fields.
  generate
    if (IWIDTH > 8) begin : g_op_wide
      assign op_ext = {{(IWIDTH-8){1'b0}}, op_byte};
    end else if (IWIDTH == 8) begin : g_op_same
      assign op_ext = op_byte;
    end else begin : g_op_narrow
      assign op_ext = op_byte[IWIDTH-1:0];
    end

    if (WIDTH > 8) begin : g_imm_wide
      assign imm_ext = {{(WIDTH-8){1'b0}}, prog_data[7:0]};
    end else if (WIDTH == 8) begin : g_imm_same
      assign imm_ext = prog_data[7:0];
    end else begin : g_imm_narrow
      assign imm_ext = prog_data[WIDTH-1:0];
    end
  endgenerate

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      prog_req_reg <= 1'b0;
      pc_reg       <= '0;
      valid_reg    <= 1'b0;
      halt_reg     <= 1'b0;
      op_code_reg  <= '0;
      src1_reg     <= '0;
      src2_reg     <= '0;
      rf_addr_reg  <= '0;
      mem_addr_reg <= '0;
      imm_reg      <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      prog_req_reg <= prog_req_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      halt_reg     <= halt_next;
      op_code_reg  <= op_code_next;
      src1_reg     <= src1_next;
      src2_reg     <= src2_next;
      rf_addr_reg  <= rf_addr_next;
      mem_addr_reg <= mem_addr_next;
      imm_reg      <= imm_next;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_reg  <= illegal_next;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    halt_next     = halt_reg;
    op_code_next  = op_code_reg;
    src1_next     = src1_reg;
    src2_next     = src2_reg;
    rf_addr_next  = rf_addr_reg;
    mem_addr_next = mem_addr_reg;
    imm_next      = imm_reg;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_next  = illegal_reg;
`endif

    case (state_reg)
      FETCH: begin
        if (jump_en) begin
          // Redirect wins over a same-cycle ack; the word is discarded.
          pc_next    = jump_target;
          valid_next = 1'b0;
        end else if (ack_take) begin
          op_code_next  = op_ext;
          src1_next     = prog_data[23:22];
          src2_next     = prog_data[21:20];
          rf_addr_next  = prog_data[19:16];
          mem_addr_next = prog_data[15:8];
          imm_next      = imm_ext;
          if (is_halt_op) begin
            state_next = HALT;
            halt_next  = 1'b1;
          end
`ifdef DECODE_ILLEGAL_TRAP_EN
          else if (!is_legal) begin
            state_next   = HALT;
            halt_next    = 1'b1;
            illegal_next = 1'b1;
          end
`endif
          else begin
            state_next = ISSUE;
            valid_next = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (jump_en) begin
          // Jump drops the held instruction even while stalled.
          state_next = FETCH;
          pc_next    = jump_target;
          valid_next = 1'b0;
        end else if (!stall) begin
          state_next = FETCH;
          pc_next    = pc_reg + PC_WIDTH'(1);
          valid_next = 1'b0;
        end
      end

      HALT: begin
        // Everything held; jump_en and prog_ack are ignored.
      end

      default: begin
        state_next = FETCH;
      end
    endcase

    // prog_req is a register so it is low during reset and rises on the
    // first edge after release; it falls on the ack edge.
    prog_req_next = (state_next == FETCH);
  end

  assign prog_req       = prog_req_reg;
  assign prog_addr      = pc_reg;
  assign pc             = pc_reg;
  assign instr_valid    = valid_reg;
  assign halt           = halt_reg;
  assign op_code        = op_code_reg;
  assign source1_choice = src1_reg;
  assign source2_choice = src2_reg;
  assign rf_addr        = rf_addr_reg;
  assign mem_addr       = mem_addr_reg;
  assign imm            = imm_reg;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_op     = illegal_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_decode
//
// Directed testbench for instr_fetch_decode with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        prog_req;
  logic [7:0]  prog_addr;
  logic        prog_ack;
  logic [31:0] prog_data;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_target;
  logic [7:0]  op_code;
  logic [1:0]  source1_choice;
  logic [1:0]  source2_choice;
  logic [3:0]  rf_addr;
  logic [7:0]  mem_addr;
  logic [7:0]  imm;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halt;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int checks;
  int errors;

  instr_fetch_decode #(
    .WIDTH    (8),
    .IWIDTH   (8),
    .PC_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prog_req       (prog_req),
    .prog_addr      (prog_addr),
    .prog_ack       (prog_ack),
    .prog_data      (prog_data),
    .stall          (stall),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .op_code        (op_code),
    .source1_choice (source1_choice),
    .source2_choice (source2_choice),
    .rf_addr        (rf_addr),
    .mem_addr       (mem_addr),
    .imm            (imm),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .halt           (halt)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_op     (illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for a request, acks it for one cycle with the given
  // word and returns at the falling edge after the capture edge.
  task automatic fetch_word(input logic [31:0] word, input string name);
    int n;
    n = 0;
    while (prog_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (prog_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout prog_req=%b required 1", name, prog_req);
    end
    prog_ack  = 1'b1;
    prog_data = word;
    @(negedge clk);
    prog_ack  = 1'b0;
    $display("fetch %s word=%08h pc=%02h valid=%b halt=%b", name, word, pc, instr_valid, halt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prog_ack = 1'b1; prog_data = 32'h0511_2233;
    stall = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (prog_req !== 1'b0 || prog_addr !== 8'h00 || pc !== 8'h00 || instr_valid !== 1'b0 ||
        halt !== 1'b0 || op_code !== 8'h00 || source1_choice !== 2'd0 || source2_choice !== 2'd0 ||
        rf_addr !== 4'h0 || mem_addr !== 8'h00 || imm !== 8'h00) begin
      errors++;
      $display("FAIL reset_state req=%b addr=%02h pc=%02h valid=%b halt=%b op=%02h s1=%0d s2=%0d rf=%0h mem=%02h imm=%02h required all zero",
               prog_req, prog_addr, pc, instr_valid, halt, op_code, source1_choice, source2_choice, rf_addr, mem_addr, imm);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal illegal_op=%b required 0", illegal_op);
    end
`endif
    $display("reset: req=%b pc=%02h valid=%b", prog_req, pc, instr_valid);
    prog_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_decode();
    @(negedge clk);
    checks++;
    if (prog_req !== 1'b1 || prog_addr !== 8'h00) begin
      errors++;
      $display("FAIL first_req prog_req=%b prog_addr=%02h required 1/00", prog_req, prog_addr);
    end
    prog_ack = 1'b1; prog_data = 32'h07E5_3C12; stall = 1'b1;
    @(negedge clk);
    prog_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || op_code !== 8'h07 || source1_choice !== 2'd3 || source2_choice !== 2'd2 ||
        rf_addr !== 4'h5 || mem_addr !== 8'h3C || imm !== 8'h12 || pc !== 8'h00 || prog_req !== 1'b0) begin
      errors++;
      $display("FAIL decode valid=%b op=%02h s1=%0d s2=%0d rf=%0h mem=%02h imm=%02h pc=%02h req=%b required 1/07/3/2/5/3C/12/00/0",
               instr_valid, op_code, source1_choice, source2_choice, rf_addr, mem_addr, imm, pc, prog_req);
    end
    $display("decode: op=%02h imm=%02h pc=%02h valid=%b", op_code, imm, pc, instr_valid);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || op_code !== 8'h07 || mem_addr !== 8'h3C || imm !== 8'h12 ||
          pc !== 8'h00 || prog_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d valid=%b op=%02h mem=%02h imm=%02h pc=%02h req=%b required 1/07/3C/12/00/0",
                 i, instr_valid, op_code, mem_addr, imm, pc, prog_req);
      end
      $display("stall cycle %0d: valid=%b op=%02h", i, instr_valid, op_code);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h01 || prog_req !== 1'b1 || prog_addr !== 8'h01) begin
      errors++;
      $display("FAIL stall_release valid=%b pc=%02h req=%b addr=%02h required 0/01/1/01",
               instr_valid, pc, prog_req, prog_addr);
    end
    $display("stall release: pc=%02h req=%b", pc, prog_req);
  endtask

  task automatic test_jump_ack();
    prog_ack = 1'b1; prog_data = 32'h0900_0000; jump_en = 1'b1; jump_target = 8'h40;
    @(negedge clk);
    prog_ack = 1'b0; jump_en = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || prog_req !== 1'b1 || prog_addr !== 8'h40 || op_code !== 8'h07) begin
      errors++;
      $display("FAIL jump_ack valid=%b req=%b addr=%02h op=%02h required 0/1/40/07",
               instr_valid, prog_req, prog_addr, op_code);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || prog_addr !== 8'h40) begin
      errors++;
      $display("FAIL jump_no_pulse valid=%b addr=%02h required 0/40", instr_valid, prog_addr);
    end
    fetch_word(32'h0A00_0055, "after_jump");
    checks++;
    if (instr_valid !== 1'b1 || op_code !== 8'h0A || imm !== 8'h55 || pc !== 8'h40) begin
      errors++;
      $display("FAIL jump_fetch valid=%b op=%02h imm=%02h pc=%02h required 1/0A/55/40",
               instr_valid, op_code, imm, pc);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h41) begin
      errors++;
      $display("FAIL jump_consume valid=%b pc=%02h required 0/41", instr_valid, pc);
    end
  endtask

  task automatic test_jump_issue();
    stall = 1'b1;
    fetch_word(32'h1B00_0033, "stalled");
    checks++;
    if (instr_valid !== 1'b1 || op_code !== 8'h1B || pc !== 8'h41) begin
      errors++;
      $display("FAIL issue_hold valid=%b op=%02h pc=%02h required 1/1B/41", instr_valid, op_code, pc);
    end
    jump_en = 1'b1; jump_target = 8'h80;
    @(negedge clk);
    jump_en = 1'b0; stall = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h80 || prog_req !== 1'b1 || prog_addr !== 8'h80) begin
      errors++;
      $display("FAIL jump_issue valid=%b pc=%02h req=%b addr=%02h required 0/80/1/80",
               instr_valid, pc, prog_req, prog_addr);
    end
    $display("jump in issue: pc=%02h", pc);
  endtask

  task automatic test_wrap();
    jump_en = 1'b1; jump_target = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    fetch_word(32'h2000_0001, "wrap");
    checks++;
    if (instr_valid !== 1'b1 || pc !== 8'hFF || op_code !== 8'h20) begin
      errors++;
      $display("FAIL wrap_issue valid=%b pc=%02h op=%02h required 1/FF/20", instr_valid, pc, op_code);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h00 || prog_addr !== 8'h00 || prog_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap pc=%02h addr=%02h valid=%b req=%b required 00/00/0/1",
               pc, prog_addr, instr_valid, prog_req);
    end
    $display("wrap: pc=%02h", pc);
  endtask

  task automatic test_illegal();
    fetch_word(32'h1500_0000, "illegal");
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++;
    if (illegal_op !== 1'b1 || halt !== 1'b1 || instr_valid !== 1'b0 || prog_req !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap illegal_op=%b halt=%b valid=%b req=%b required 1/1/0/0",
               illegal_op, halt, instr_valid, prog_req);
    end
`else
    checks++;
    if (instr_valid !== 1'b1 || op_code !== 8'h15 || halt !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL illegal_issue valid=%b op=%02h halt=%b pc=%02h required 1/15/0/00",
               instr_valid, op_code, halt, pc);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_halt();
    // Asynchronous reset: outputs clear without waiting for a clock edge.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (prog_req !== 1'b0 || pc !== 8'h00 || halt !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset req=%b pc=%02h halt=%b valid=%b required 0/00/0/0",
               prog_req, pc, halt, instr_valid);
    end
    prog_ack = 1'b1; prog_data = 32'h0700_0000;
    repeat (2) @(negedge clk);
    prog_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (prog_req !== 1'b1 || prog_addr !== 8'h00 || instr_valid !== 1'b0 || op_code !== 8'h00) begin
      errors++;
      $display("FAIL reset_ack_ignored req=%b addr=%02h valid=%b op=%02h required 1/00/0/00",
               prog_req, prog_addr, instr_valid, op_code);
    end
    fetch_word(32'hFF00_0000, "halt");
    checks++;
    if (halt !== 1'b1 || instr_valid !== 1'b0 || prog_req !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL halt_enter halt=%b valid=%b req=%b pc=%02h required 1/0/0/00",
               halt, instr_valid, prog_req, pc);
    end
    jump_en = 1'b1; jump_target = 8'h22; prog_ack = 1'b1; prog_data = 32'h0100_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || instr_valid !== 1'b0 || prog_req !== 1'b0 || pc !== 8'h00) begin
        errors++;
        $display("FAIL halt_hold_%0d halt=%b valid=%b req=%b pc=%02h required 1/0/0/00",
                 i, halt, instr_valid, prog_req, pc);
      end
      $display("halt cycle %0d: halt=%b pc=%02h", i, halt, pc);
    end
    jump_en = 1'b0; prog_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear halt=%b required 0", halt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_decode();
    test_stall();
    test_jump_ack();
    test_jump_issue();
    test_wrap();
    test_illegal();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
